// File: rtl/greater_checker.sv
// rtl/greater_checker.sv - pipelined greater-than result checker with pass/fail verdict
module greater_checker #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [15:0]      num_checks,
  input  logic             stop_on_err,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             r,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             err_pulse,
  output logic [15:0]      check_cnt,
  output logic [7:0]       err_cnt,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL} state_t;

  state_t                        state_q, state_d;
  logic [LATENCY-1:0]            pv_q, pv_d;
  logic [LATENCY-1:0]            pg_q, pg_d;
  logic [LATENCY-1:0][WIDTH-1:0] pa_q, pa_d;
  logic [LATENCY-1:0][WIDTH-1:0] pb_q, pb_d;
  logic [15:0]                   num_checks_q, num_checks_d;
  logic                          stop_q, stop_d;
  logic [15:0]                   check_cnt_q, check_cnt_d;
  logic [7:0]                    err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0]              fea_q, fea_d;
  logic [WIDTH-1:0]              feb_q, feb_d;
  logic                          err_pulse_q, err_pulse_d;
  logic                          busy_q, busy_d;
  logic                          pass_q, pass_d;
  logic                          fail_q, fail_d;
  logic                          cmp_ev;
  logic                          mismatch;
  logic [15:0]                   cnt_next;

  // Next-state: expected-result pipeline, run counters, verdict FSM
  always_comb begin
    cmp_ev       = pv_q[LATENCY-1] && (state_q == ST_RUN);
    mismatch     = cmp_ev && (pg_q[LATENCY-1] != r);
    cnt_next     = check_cnt_q + 16'd1;
    state_d      = state_q;
    num_checks_d = num_checks_q;
    stop_d       = stop_q;
    check_cnt_d  = check_cnt_q;
    err_cnt_d    = err_cnt_q;
    fea_d        = fea_q;
    feb_d        = feb_q;
    err_pulse_d  = 1'b0;

    // The pipeline shifts every cycle so r always lines up with its operands
    pv_d[0] = in_valid;
    pg_d[0] = (a > b);
    pa_d[0] = a;
    pb_d[0] = b;
    for (int i = 1; i < LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pg_d[i] = pg_q[i-1];
      pa_d[i] = pa_q[i-1];
      pb_d[i] = pb_q[i-1];
    end

    if (start) begin
      // Dropping every valid bit discards both in-flight results and the
      // operands presented alongside start
      pv_d         = '0;
      num_checks_d = num_checks;
      stop_d       = stop_on_err;
      check_cnt_d  = '0;
      err_cnt_d    = '0;
      fea_d        = '0;
      feb_d        = '0;
      state_d      = (num_checks == 16'd0) ? ST_PASS : ST_RUN;
    end else if (cmp_ev) begin
      check_cnt_d = cnt_next;
      if (mismatch) begin
        err_pulse_d = 1'b1;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
        // err_cnt saturates instead of wrapping, so zero means first mismatch
        if (err_cnt_q == 8'd0) begin
          fea_d = pa_q[LATENCY-1];
          feb_d = pb_q[LATENCY-1];
        end
      end
      if (cnt_next == num_checks_q) begin
        state_d = (mismatch || (err_cnt_q != 8'd0)) ? ST_FAIL : ST_PASS;
      end else if (mismatch && stop_q) begin
        state_d = ST_FAIL;
      end
    end

    busy_d = (state_d == ST_RUN);
    pass_d = (state_d == ST_PASS);
    fail_d = (state_d == ST_FAIL);
  end

  // Register all state and outputs; reset overrides every other input
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      pv_q         <= '0;
      pg_q         <= '0;
      pa_q         <= '0;
      pb_q         <= '0;
      num_checks_q <= '0;
      stop_q       <= 1'b0;
      check_cnt_q  <= '0;
      err_cnt_q    <= '0;
      fea_q        <= '0;
      feb_q        <= '0;
      err_pulse_q  <= 1'b0;
      busy_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pv_q         <= pv_d;
      pg_q         <= pg_d;
      pa_q         <= pa_d;
      pb_q         <= pb_d;
      num_checks_q <= num_checks_d;
      stop_q       <= stop_d;
      check_cnt_q  <= check_cnt_d;
      err_cnt_q    <= err_cnt_d;
      fea_q        <= fea_d;
      feb_q        <= feb_d;
      err_pulse_q  <= err_pulse_d;
      busy_q       <= busy_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
    end
  end

  assign busy        = busy_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign err_pulse   = err_pulse_q;
  assign check_cnt   = check_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign first_err_a = fea_q;
  assign first_err_b = feb_q;

endmodule

// File: tb/tb_greater_checker.sv
// tb/tb_greater_checker.sv - scoreboard bench for greater_checker with random operand runs
module tb_greater_checker;

  localparam int LAT = 2;

  logic        CLK, RST, start, stop_on_err, in_valid, r;
  logic [15:0] num_checks;
  logic [7:0]  a, b;
  logic        busy, pass, fail, err_pulse;
  logic [15:0] check_cnt;
  logic [7:0]  err_cnt, first_err_a, first_err_b;

  greater_checker #(.WIDTH(8), .LATENCY(LAT)) dut (
    .CLK(CLK), .RST(RST), .start(start), .num_checks(num_checks),
    .stop_on_err(stop_on_err), .in_valid(in_valid), .a(a), .b(b), .r(r),
    .busy(busy), .pass(pass), .fail(fail), .err_pulse(err_pulse),
    .check_cnt(check_cnt), .err_cnt(err_cnt),
    .first_err_a(first_err_a), .first_err_b(first_err_b)
  );

  typedef struct {
    bit         p;
    bit         f;
    int         cnt;
    int         err;
    logic [7:0] fa;
    logic [7:0] fb;
    int         pulses;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit         qf[$];
  bit         hist[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         pulse_cnt = 0;
  bit         last_start = 0;
  bit         vd_prev = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input longint act, input longint expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [7:0] rnd();
    return 8'($urandom_range(0, 255));
  endfunction

  // Reference: walk the valid pairs of a run and apply the verdict rules
  function automatic exp_t model(input int n, input bit stop);
    exp_t e;
    int   errs = 0;
    int   cnt = 0;
    e = '{default: 0};
    if (n == 0) begin
      e.p = 1;
      return e;
    end
    foreach (qa[i]) begin
      cnt++;
      if (qf[i]) begin
        errs++;
        if (errs == 1) begin
          e.fa = qa[i];
          e.fb = qb[i];
        end
      end
      if ((qf[i] && stop) || cnt == n) break;
    end
    e.cnt    = cnt;
    e.err    = (errs > 255) ? 255 : errs;
    e.pulses = errs;
    e.f      = (errs > 0);
    e.p      = (errs == 0);
    return e;
  endfunction

  // One cycle of stimulus; r carries the (possibly flipped) a>b from LAT cycles ago
  task automatic drive(input bit st, input bit v, input logic [7:0] x, input logic [7:0] y,
                       input bit flip);
    @(posedge CLK);
    #1;
    if (last_start) pulse_cnt = 0;
    last_start = st;
    start      = st;
    in_valid   = v;
    a          = x;
    b          = y;
    r          = hist.pop_front();
    hist.push_back(v ? ((x > y) ^ flip) : bit'($urandom_range(0, 1)));
  endtask

  task automatic fill(input int cnt, input int flip_pct);
    qa.delete();
    qb.delete();
    qf.delete();
    repeat (cnt) begin
      qa.push_back(rnd());
      qb.push_back(rnd());
      qf.push_back($urandom_range(0, 99) < flip_pct);
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    while (expq.size() != 0 && k < 200) begin
      @(posedge CLK);
      k++;
    end
    if (expq.size() != 0) begin
      chk("verdict_timeout", expq.size(), 0);
      expq.delete();
    end
  endtask

  task automatic run(input int n, input bit stop, input bit chk0);
    expq.push_back(model(n, stop));
    num_checks  = 16'(n);
    stop_on_err = stop;
    drive(1, 1, rnd(), rnd(), 1);
    foreach (qa[i]) begin
      if (!(chk0 && i == 0) && $urandom_range(0, 3) == 0)
        drive(0, 0, rnd(), rnd(), 0);
      drive(0, 1, qa[i], qb[i], qf[i]);
      if (chk0 && i == 0) begin
        @(negedge CLK);
        chk("restart_check_cnt", check_cnt, 0);
        chk("restart_err_cnt", err_cnt, 0);
        chk("restart_busy", busy, 1);
      end
    end
    repeat (LAT + 3) drive(0, 0, rnd(), rnd(), 0);
    wait_drain();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_err_pulse"}, err_pulse, 0);
    chk({tag, "_check_cnt"}, check_cnt, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_first_err_a"}, first_err_a, 0);
    chk({tag, "_first_err_b"}, first_err_b, 0);
  endtask

  // Monitor: count error pulses and score each new verdict against the queue
  initial begin
    exp_t e;
    bit   vd;
    forever begin
      @(negedge CLK);
      if (err_pulse) pulse_cnt++;
      vd = pass || fail;
      if (vd && !vd_prev && !RST) begin
        if (expq.size() == 0) begin
          chk("unexpected_verdict", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("verdict_pass", pass, e.p);
          chk("verdict_fail", fail, e.f);
          chk("verdict_busy", busy, 0);
          chk("verdict_check_cnt", check_cnt, e.cnt);
          chk("verdict_err_cnt", err_cnt, e.err);
          chk("verdict_first_err_a", first_err_a, e.fa);
          chk("verdict_first_err_b", first_err_b, e.fb);
          chk("verdict_err_pulses", pulse_cnt, e.pulses);
        end
      end
      vd_prev = vd;
    end
  end

  initial begin
    int  k;
    bit  reached;
    logic [7:0] x;
    RST = 1; start = 0; num_checks = 0; stop_on_err = 0;
    in_valid = 0; a = 0; b = 0; r = 0;
    repeat (LAT) hist.push_back(0);

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_all_zero("reset");
    @(posedge CLK);
    #1 RST = 0;

    // Zero-length run goes straight to PASS
    fill(0, 0);
    expq.push_back(model(0, 0));
    num_checks = 0;
    stop_on_err = 0;
    drive(1, 1, rnd(), rnd(), 1);
    drive(0, 0, rnd(), rnd(), 0);
    @(negedge CLK);
    chk("zero_run_pass", pass, 1);
    chk("zero_run_check_cnt", check_cnt, 0);
    wait_drain();

    // Clean 100-pair run
    fill(100, 0);
    run(100, 0, 0);

    // Single corrupted result on 5 > 3
    fill(100, 0);
    k = $urandom_range(0, 99);
    qa[k] = 8'h05; qb[k] = 8'h03; qf[k] = 1;
    run(100, 0, 0);

    // Stop at first error on the 10th pair; later mismatches ignored
    fill(30, 0);
    qf[9] = 1; qf[15] = 1; qf[25] = 1;
    run(100, 1, 0);
    chk("stop_hold_check_cnt", check_cnt, 10);
    chk("stop_hold_err_cnt", err_cnt, 1);
    chk("stop_hold_busy", busy, 0);
    chk("stop_hold_fail", fail, 1);

    // r stuck at 0 with a > b on every pair: err_cnt saturates
    qa.delete(); qb.delete(); qf.delete();
    repeat (300) begin
      x = 8'($urandom_range(1, 255));
      qa.push_back(x);
      qb.push_back(8'($urandom_range(0, int'(x) - 1)));
      qf.push_back(1);
    end
    run(300, 0, 0);

    // Restart mid-run with results still in flight
    fill(4, 100);
    num_checks = 50;
    stop_on_err = 0;
    drive(1, 1, rnd(), rnd(), 1);
    foreach (qa[i]) drive(0, 1, qa[i], qb[i], qf[i]);
    fill(20, 15);
    run(20, 0, 1);

    // Reset at check_cnt == 50 aborts the run without a verdict
    fill(100, 10);
    num_checks = 100;
    stop_on_err = 0;
    drive(1, 1, rnd(), rnd(), 1);
    reached = 0;
    foreach (qa[i]) begin
      drive(0, 1, qa[i], qb[i], qf[i]);
      if (check_cnt == 16'd50) begin
        reached = 1;
        break;
      end
    end
    chk("reach_check_cnt_50", reached, 1);
    RST = 1;
    @(posedge CLK);
    @(negedge CLK);
    chk_all_zero("midrun_reset");
    @(posedge CLK);
    #1 RST = 0;
    fill(40, 10);
    run(40, 0, 0);

    // Random runs
    repeat (6) begin
      int  n;
      bit  st;
      n  = $urandom_range(1, 40);
      st = bit'($urandom_range(0, 1));
      fill(n + $urandom_range(0, 5), 12);
      run(n, st, 0);
    end

    chk("scoreboard_empty", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
